// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: Moore FSM with memory-handshake wait states,
// a bounded wait counter, and sticky illegal-opcode / memory-timeout fault flags.
module multicycle_control #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Function,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCondEQ,
  output logic       PCWriteCondNE,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Link,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ShamtSelector,
  output logic [3:0] State,
  output logic       InstrDone,
  output logic       IllegalOp,
  output logic       MemFault
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB   = 4'd7,
    BRANCH = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, JUMP  = 4'd11,
    JAL    = 4'd12, HALT   = 4'd15
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  stateT      stateReg;
  stateT      readyNext;
  logic [7:0] waitCntReg;
  logic       illegalOpReg;
  logic       memFaultReg;
  logic       memTimeout;
  logic       unusedZero;

  // Branch qualification by Zero happens in the datapath, not here.
  assign unusedZero = Zero;

  // The counter holds the number of cycles already spent waiting, so the
  // MEM_WAIT_MAX-th unanswered cycle is the one that times out.
  assign memTimeout = !MemReady && (waitCntReg == WAIT_LAST);
  assign readyNext  = (stateReg == FETCH) ? DECODE :
                      (stateReg == MEMRD) ? MEMWB  : FETCH;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= FETCH;
      waitCntReg   <= '0;
      illegalOpReg <= 1'b0;
      memFaultReg  <= 1'b0;
    end else begin
      waitCntReg <= '0;
      case (stateReg)
        FETCH, MEMRD, MEMWR: begin
          if (MemReady) begin
            stateReg <= readyNext;
          end else if (memTimeout) begin
            stateReg    <= HALT;
            memFaultReg <= 1'b1;
          end else begin
            waitCntReg <= waitCntReg + 8'd1;
          end
        end
        DECODE: begin
          case (OP)
            OP_RTYPE:               stateReg <= EXEC;
            OP_LW, OP_SW:           stateReg <= MEMADR;
            OP_BEQ, OP_BNE:         stateReg <= BRANCH;
            OP_ADDI, OP_ORI, OP_LUI: stateReg <= IEXEC;
            OP_J:                   stateReg <= JUMP;
            OP_JAL:                 stateReg <= JAL;
            default: begin
              stateReg     <= HALT;
              illegalOpReg <= 1'b1;
            end
          endcase
        end
        MEMADR:                            stateReg <= (OP == OP_SW) ? MEMWR : MEMRD;
        EXEC:                              stateReg <= RWB;
        IEXEC:                             stateReg <= IWB;
        MEMWB, RWB, BRANCH, IWB, JUMP, JAL: stateReg <= FETCH;
        default:                           stateReg <= HALT;
      endcase
    end
  end

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    PCSource      = 2'b00;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    Link          = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 3'b000;
    ShamtSelector = 1'b0;
    InstrDone     = 1'b0;
    State         = stateReg;
    IllegalOp     = illegalOpReg;
    MemFault      = memFaultReg;
    case (stateReg)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 3'b100;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = 3'b100;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 3'b100;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
      end
      EXEC: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 3'b111;
        ShamtSelector = (Function == 6'h00) || (Function == 6'h02);
      end
      RWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        PCSource      = 2'b01;
        PCWriteCondEQ = (OP == OP_BEQ);
        PCWriteCondNE = (OP == OP_BNE);
        InstrDone     = 1'b1;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (OP)
          OP_ORI:  ALUOp = 3'b101;
          OP_LUI:  ALUOp = 3'b110;
          default: ALUOp = 3'b100;
        endcase
      end
      IWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      JUMP, JAL: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        InstrDone = 1'b1;
        RegWrite  = (stateReg == JAL);
        Link      = (stateReg == JAL);
      end
      default: ;
    endcase
    // Nothing may commit while reset is held, whatever state is being abandoned.
    if (reset) begin
      PCWrite       = 1'b0;
      PCWriteCondEQ = 1'b0;
      PCWriteCondNE = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      MemWrite      = 1'b0;
      Link          = 1'b0;
      InstrDone     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected state paths built from the
// instruction class and planned memory delays, checked cycle by cycle.
module tb_multicycle_control;

  localparam int MAXW = 3;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                         S_MEMRD = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                         S_EXEC  = 4'd6,  S_RWB    = 4'd7,  S_BRANCH = 4'd8,
                         S_IEXEC = 4'd9,  S_IWB    = 4'd10, S_JUMP   = 4'd11,
                         S_JAL   = 4'd12, S_HALT   = 4'd15;

  typedef struct packed {
    logic       pcWrite;
    logic       condEq;
    logic       condNe;
    logic [1:0] pcSource;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       link;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       shamt;
    logic       instrDone;
  } ctrlT;

  typedef struct {
    logic [3:0] st;
    bit         rdy;
    bit         isWait;
  } stepT;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP;
  logic [5:0] Function;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, PCWriteCondEQ, PCWriteCondNE;
  logic [1:0] PCSource;
  logic       IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, Link;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       ShamtSelector;
  logic [3:0] State;
  logic       InstrDone, IllegalOp, MemFault;

  int testsRun = 0;
  int testsFailed = 0;
  bit expIllegal = 1'b0;
  bit expFault = 1'b0;

  logic [5:0] legalOps [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                                6'h08, 6'h0D, 6'h0F, 6'h02, 6'h03};
  logic [5:0] functs [6] = '{6'h00, 6'h02, 6'h20, 6'h22, 6'h03, 6'h2A};

  multicycle_control #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Function(Function), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ),
    .PCWriteCondNE(PCWriteCondNE), .PCSource(PCSource), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Link(Link), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ShamtSelector(ShamtSelector),
    .State(State), .InstrDone(InstrDone), .IllegalOp(IllegalOp), .MemFault(MemFault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control word each state must present, straight from the per-state output table.
  function automatic ctrlT ctrlFor(input logic [3:0] st, input logic [5:0] op,
                                   input logic [5:0] fn, input bit rdy);
    ctrlT c;
    c = '0;
    case (st)
      S_FETCH:  begin c.memRead = 1; c.aluSrcB = 2'b01; c.aluOp = 3'b100;
                      c.irWrite = rdy; c.pcWrite = rdy; end
      S_DECODE: begin c.aluSrcB = 2'b11; c.aluOp = 3'b100; end
      S_MEMADR: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; c.aluOp = 3'b100; end
      S_MEMRD:  begin c.memRead = 1; c.iorD = 1; end
      S_MEMWB:  begin c.regWrite = 1; c.memtoReg = 1; c.instrDone = 1; end
      S_MEMWR:  begin c.memWrite = 1; c.iorD = 1; c.instrDone = rdy; end
      S_EXEC:   begin c.aluSrcA = 1; c.aluOp = 3'b111;
                      c.shamt = (fn == 6'h00 || fn == 6'h02); end
      S_RWB:    begin c.regWrite = 1; c.regDst = 1; c.instrDone = 1; end
      S_BRANCH: begin c.aluSrcA = 1; c.pcSource = 2'b01; c.instrDone = 1;
                      c.condEq = (op == 6'h04); c.condNe = (op == 6'h05); end
      S_IEXEC:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10;
                      c.aluOp = (op == 6'h08) ? 3'b100 : (op == 6'h0D) ? 3'b101 : 3'b110; end
      S_IWB:    begin c.regWrite = 1; c.instrDone = 1; end
      S_JUMP:   begin c.pcWrite = 1; c.pcSource = 2'b10; c.instrDone = 1; end
      S_JAL:    begin c.pcWrite = 1; c.pcSource = 2'b10; c.instrDone = 1;
                      c.regWrite = 1; c.link = 1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic int specLatency(input logic [5:0] op);
    case (op)
      6'h23:                return 5;
      6'h2B, 6'h00:         return 4;
      6'h08, 6'h0D, 6'h0F:  return 4;
      default:              return 3;
    endcase
  endfunction

  task automatic stepCheck(input logic [3:0] expSt, input bit rdy, output bit sawDone);
    ctrlT expC, obsC;
    MemReady = rdy;
    Zero = 1'($urandom);
    @(negedge clk);
    expC = ctrlFor(expSt, OP, Function, rdy);
    obsC = {PCWrite, PCWriteCondEQ, PCWriteCondNE, PCSource, IorD, MemRead, MemWrite,
            IRWrite, RegDst, MemtoReg, RegWrite, Link, ALUSrcA, ALUSrcB, ALUOp,
            ShamtSelector, InstrDone};
    chk($sformatf("state(exp %0d)", expSt), 32'(State), 32'(expSt));
    chk($sformatf("ctrl(state %0d)", expSt), 32'(obsC), 32'(expC));
    chk("IllegalOp", 32'(IllegalOp), 32'(expIllegal));
    chk("MemFault", 32'(MemFault), 32'(expFault));
    sawDone = (InstrDone === 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input bit rdy);
    reset = 1'b1;
    MemReady = rdy;
    @(negedge clk);
    chk("strobes_in_reset",
        32'({PCWrite, PCWriteCondEQ, PCWriteCondNE, IRWrite, RegWrite, MemWrite, InstrDone}), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    expIllegal = 1'b0;
    expFault = 1'b0;
  endtask

  task automatic runInstr(input logic [5:0] op, input logic [5:0] funct, input int fetchWait,
                          input int memWait, input int haltCycles);
    stepT path[$];
    bit illegal, fault, sawDone, rdy;
    int doneCount, doneAt, expLat;
    logic [3:0] memSt;
    illegal = 0; fault = 0; doneCount = 0; doneAt = 0;
    Function = funct;
    if (fetchWait >= MAXW) begin
      repeat (MAXW) path.push_back('{S_FETCH, 1'b0, 1'b1});
      fault = 1;
    end else begin
      repeat (fetchWait) path.push_back('{S_FETCH, 1'b0, 1'b1});
      path.push_back('{S_FETCH, 1'b1, 1'b1});
      path.push_back('{S_DECODE, 1'b0, 1'b0});
      case (op)
        6'h00: begin path.push_back('{S_EXEC, 0, 0}); path.push_back('{S_RWB, 0, 0}); end
        6'h23, 6'h2B: begin
          memSt = (op == 6'h2B) ? S_MEMWR : S_MEMRD;
          path.push_back('{S_MEMADR, 0, 0});
          if (memWait >= MAXW) begin
            repeat (MAXW) path.push_back('{memSt, 1'b0, 1'b1});
            fault = 1;
          end else begin
            repeat (memWait) path.push_back('{memSt, 1'b0, 1'b1});
            path.push_back('{memSt, 1'b1, 1'b1});
            if (op == 6'h23) path.push_back('{S_MEMWB, 0, 0});
          end
        end
        6'h04, 6'h05: path.push_back('{S_BRANCH, 0, 0});
        6'h08, 6'h0D, 6'h0F: begin
          path.push_back('{S_IEXEC, 0, 0}); path.push_back('{S_IWB, 0, 0});
        end
        6'h02: path.push_back('{S_JUMP, 0, 0});
        6'h03: path.push_back('{S_JAL, 0, 0});
        default: illegal = 1;
      endcase
    end
    if (illegal || fault) repeat (haltCycles) path.push_back('{S_HALT, 0, 0});
    foreach (path[i]) begin
      // The IR is only meaningful once fetched; feed junk while fetching.
      OP = (path[i].st == S_FETCH) ? 6'($urandom) : op;
      if (path[i].st == S_HALT) begin
        expIllegal |= illegal;
        expFault |= fault;
      end
      rdy = path[i].isWait ? path[i].rdy : 1'($urandom);
      stepCheck(path[i].st, rdy, sawDone);
      if (sawDone) begin
        doneCount++;
        if (doneAt == 0) doneAt = i + 1;
      end
    end
    if (illegal || fault) begin
      chk("instrDone_none", 32'(doneCount), 0);
    end else begin
      chk("instrDone_once", 32'(doneCount), 1);
      expLat = specLatency(op) + fetchWait + ((op == 6'h23 || op == 6'h2B) ? memWait : 0);
      chk($sformatf("latency op=%02h", op), 32'(doneAt), 32'(expLat));
    end
    $display("[TB] op=%02h funct=%02h fetchWait=%0d memWait=%0d cycles=%0d done=%0d",
             op, funct, fetchWait, memWait, path.size(), doneCount);
  endtask

  initial begin
    bit sawDone;
    reset = 1'b1; MemReady = 1'b0; OP = '0; Function = '0; Zero = 1'b0;
    @(posedge clk);
    #1;
    applyReset(1'b1);
    stepCheck(S_FETCH, 1'b0, sawDone);

    // Directed: zero-wait latency and decode of each class
    runInstr(6'h23, 6'h00, 0, 0, 0);
    runInstr(6'h05, 6'h00, 0, 0, 0);
    runInstr(6'h04, 6'h00, 0, 0, 0);
    runInstr(6'h00, 6'h02, 0, 0, 0);
    runInstr(6'h00, 6'h20, 0, 0, 0);
    runInstr(6'h2B, 6'h00, 0, 0, 0);
    runInstr(6'h08, 6'h00, 0, 0, 0);
    runInstr(6'h0D, 6'h00, 0, 0, 0);
    runInstr(6'h0F, 6'h00, 0, 0, 0);
    runInstr(6'h02, 6'h00, 0, 0, 0);
    runInstr(6'h03, 6'h00, 0, 0, 0);

    // Random instruction mix with memory delays inside the limit
    for (int n = 0; n < 40; n++) begin
      runInstr(legalOps[$urandom_range(0, 9)], functs[$urandom_range(0, 5)],
               $urandom_range(0, MAXW - 1), $urandom_range(0, MAXW - 1), 0);
    end

    // Illegal opcode parks in HALT until reset
    runInstr(6'h3F, 6'h00, 0, 0, 20);
    applyReset(1'b0);
    stepCheck(S_FETCH, 1'b0, sawDone);

    // Store timeout, then ready arriving on the last allowed cycle
    runInstr(6'h2B, 6'h00, 0, MAXW, 5);
    applyReset(1'b0);
    runInstr(6'h2B, 6'h00, 0, MAXW - 1, 0);
    runInstr(6'h23, 6'h00, 0, MAXW - 1, 0);

    // Fetch timeout
    runInstr(6'h23, 6'h00, MAXW, 0, 4);
    applyReset(1'b0);

    // Reset in the middle of a load read
    OP = 6'h23; Function = 6'h00;
    stepCheck(S_FETCH, 1'b1, sawDone);
    stepCheck(S_DECODE, 1'b0, sawDone);
    stepCheck(S_MEMADR, 1'b0, sawDone);
    stepCheck(S_MEMRD, 1'b0, sawDone);
    applyReset(1'b0);
    stepCheck(S_FETCH, 1'b0, sawDone);

    // Reset while JAL would commit PC and $31
    OP = 6'h03;
    stepCheck(S_FETCH, 1'b1, sawDone);
    stepCheck(S_DECODE, 1'b0, sawDone);
    applyReset(1'b1);
    stepCheck(S_FETCH, 1'b0, sawDone);
    runInstr(6'h00, 6'h00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
